// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: FSM states,
// error codes, common command bytes and small helper functions.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5,
        ST_FAIL      = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_START = 2'd1;  // device never started clocking
    localparam logic [1:0] ERR_XFER  = 2'd2;  // frame or ACK took too long
    localparam logic [1:0] ERR_NOACK = 2'd3;  // device left data high at ACK

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_RESEND   = 8'hFE;

    localparam int TMO_W = 20;

    // Odd parity: total number of ones over data plus parity is odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Saturating increment for the timeout counters.
    function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
        return (&v) ? v : v + TMO_W'(1);
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser plus run-length glitch filter for a PS/2 pad.
// The filtered level only changes after FILTER_LEN consecutive synced
// samples disagree with it; o_fall pulses for one cycle on a 1->0 change.
module ps2_line_sync #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          r_meta;
    logic          r_sync;
    logic          r_level;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    // Bring the asynchronous pad level into the clock domain (idle bus is high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end

    // Accept a level change only after a stable run; flag falling transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_fall  <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (r_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_level <= r_sync;
                r_cnt   <= '0;
                r_fall  <= r_level;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, clock out
// start/data/parity/stop on device clock falls, then check the device ACK.
// Outputs drive open-drain enables (1 = pull the line low).
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned START_TIMEOUT  = 750000,
    parameter int unsigned XFER_TIMEOUT   = 100000,
    parameter int          FILTER_LEN     = 8
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] send_data,
    input  logic       send_valid,
    output logic       send_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       rx_inhibit,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code
);

    state_t           r_state;
    logic [8:0]       r_shift;
    logic [3:0]       r_bit_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [TMO_W-1:0] r_xfer_cnt;
    logic             r_clk_oe;
    logic             r_dat_oe;
    logic             r_done;
    logic             r_error;
    logic [1:0]       r_err_code;
    logic             r_dat_meta;
    logic             r_dat_sync;

    logic             w_clk_level;
    logic             w_clk_fall;
    logic             w_xfer_expired;

    ps2_line_sync #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_sync (
        .clk     (CLOCK_50),
        .rst     (reset),
        .i_raw   (ps2_clk_in),
        .o_level (w_clk_level),
        .o_fall  (w_clk_fall)
    );

    // Data line only needs synchronising; it is sampled at filtered clock falls.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_dat_meta <= ps2_dat_in;
            r_dat_sync <= r_dat_meta;
        end
    end

    // The transfer budget runs from the first device fall through ACK and bus idle.
    assign w_xfer_expired = (r_xfer_cnt >= TMO_W'(XFER_TIMEOUT - 1));

    // Transfer sequencer with counters and registered bus/handshake outputs.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_tmo_cnt  <= '0;
            r_xfer_cnt <= '0;
            r_clk_oe   <= 1'b0;
            r_dat_oe   <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                    if (send_valid) begin
                        // Shift register holds {parity, data}; ones fill in from the top
                        // so the tenth fall naturally releases data for the stop bit.
                        r_shift   <= {odd_parity(send_data), send_data};
                        r_tmo_cnt <= '0;
                        r_clk_oe  <= 1'b1;
                        r_state   <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (r_tmo_cnt == TMO_W'(INHIBIT_CYCLES - 1)) begin
                        r_dat_oe  <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= ST_REQ;
                    end else begin
                        r_tmo_cnt <= sat_inc(r_tmo_cnt);
                    end
                end
                ST_REQ: begin
                    // Clock is released one cycle after the start bit is driven.
                    r_clk_oe <= 1'b0;
                    if (w_clk_fall) begin
                        r_dat_oe   <= ~r_shift[0];
                        r_shift    <= {1'b1, r_shift[8:1]};
                        r_bit_cnt  <= 4'd1;
                        r_xfer_cnt <= '0;
                        r_tmo_cnt  <= '0;
                        r_state    <= ST_SHIFT;
                    end else if (r_tmo_cnt == TMO_W'(START_TIMEOUT - 1)) begin
                        r_clk_oe   <= 1'b0;
                        r_dat_oe   <= 1'b0;
                        r_error    <= 1'b1;
                        r_err_code <= ERR_START;
                        r_tmo_cnt  <= '0;
                        r_state    <= ST_FAIL;
                    end else begin
                        r_tmo_cnt <= sat_inc(r_tmo_cnt);
                    end
                end
                ST_SHIFT: begin
                    r_xfer_cnt <= sat_inc(r_xfer_cnt);
                    if (w_clk_fall) begin
                        r_dat_oe  <= ~r_shift[0];
                        r_shift   <= {1'b1, r_shift[8:1]};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd9) begin
                            r_tmo_cnt <= '0;
                            r_state   <= ST_ACK;
                        end
                    end else if (w_xfer_expired) begin
                        r_clk_oe   <= 1'b0;
                        r_dat_oe   <= 1'b0;
                        r_error    <= 1'b1;
                        r_err_code <= ERR_XFER;
                        r_tmo_cnt  <= '0;
                        r_state    <= ST_FAIL;
                    end
                end
                ST_ACK: begin
                    r_xfer_cnt <= sat_inc(r_xfer_cnt);
                    if (w_clk_fall) begin
                        r_tmo_cnt <= '0;
                        if (!r_dat_sync) begin
                            r_state <= ST_WAIT_IDLE;
                        end else begin
                            r_error    <= 1'b1;
                            r_err_code <= ERR_NOACK;
                            r_state    <= ST_FAIL;
                        end
                    end else if (w_xfer_expired) begin
                        r_clk_oe   <= 1'b0;
                        r_dat_oe   <= 1'b0;
                        r_error    <= 1'b1;
                        r_err_code <= ERR_XFER;
                        r_tmo_cnt  <= '0;
                        r_state    <= ST_FAIL;
                    end
                end
                ST_WAIT_IDLE: begin
                    r_xfer_cnt <= sat_inc(r_xfer_cnt);
                    if (w_clk_level && r_dat_sync) begin
                        r_done    <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end else if (w_xfer_expired) begin
                        r_clk_oe   <= 1'b0;
                        r_dat_oe   <= 1'b0;
                        r_error    <= 1'b1;
                        r_err_code <= ERR_XFER;
                        r_tmo_cnt  <= '0;
                        r_state    <= ST_FAIL;
                    end
                end
                ST_FAIL: begin
                    r_clk_oe  <= 1'b0;
                    r_dat_oe  <= 1'b0;
                    r_tmo_cnt <= '0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign send_ready = (r_state == ST_IDLE);
    assign rx_inhibit = (r_state != ST_IDLE);
    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;
    assign done       = r_done;
    assign error      = r_error;
    assign err_code   = r_err_code;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device on a wired-AND bus,
// an expectation queue for frames and done/error events, and a monitor
// that pops and compares whenever the DUT pulses done or error.
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int INH   = 60;
    localparam int START = 400;
    localparam int XFER  = 3000;
    localparam int FLEN  = 8;
    localparam int HP    = 40;     // device clock half period in system cycles
    localparam int LIM   = 5000;

    localparam int M_NORMAL = 0;
    localparam int M_NOCLK  = 1;
    localparam int M_NOACK  = 2;
    localparam int M_ABORT  = 3;

    typedef struct { logic [7:0] data; logic par; } frame_t;
    typedef struct { logic is_err; logic [1:0] code; } evt_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] send_data = 8'h00;
    logic       send_valid = 1'b0;
    logic       send_ready, ps2_clk_oe, ps2_dat_oe, rx_inhibit, done, error;
    logic [1:0] err_code;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    wire        bus_clk = dev_clk & ~ps2_clk_oe;
    wire        bus_dat = dev_dat & ~ps2_dat_oe;

    frame_t     exp_frames[$];
    evt_t       exp_evts[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_events = 0;
    int         ev_base = 0;
    int         n_acc = 0;
    int         cyc = 0;
    int         dev_mode = M_NORMAL;
    int         dev_falls = 0;
    bit         dev_busy = 1'b0;
    logic [1:0] hcode = 2'd0;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (START),
        .XFER_TIMEOUT   (XFER),
        .FILTER_LEN     (FLEN)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .send_data  (send_data),
        .send_valid (send_valid),
        .send_ready (send_ready),
        .ps2_clk_in (bus_clk),
        .ps2_dat_in (bus_dat),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .rx_inhibit (rx_inhibit),
        .done       (done),
        .error      (error),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && send_valid && send_ready) n_acc <= n_acc + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] b, input logic par, input int mode,
                            input logic is_err, input logic [1:0] code);
        frame_t f;
        evt_t   e;
        if (mode != M_ABORT) begin
            if (mode != M_NOCLK) begin
                f.data = b;
                f.par  = par;
                exp_frames.push_back(f);
            end
            e.is_err = is_err;
            e.code   = code;
            exp_evts.push_back(e);
        end
    endtask

    // Issue one request at a negedge; returns on the negedge after acceptance.
    task automatic send(input logic [7:0] b, input logic par, input int mode,
                        input logic is_err, input logic [1:0] code);
        dev_mode  = mode;
        dev_falls = 0;
        push_exp(b, par, mode, is_err, code);
        ev_base    = n_events;
        send_data  = b;
        send_valid = 1'b1;
        @(negedge clk);
        send_valid = 1'b0;
        $display("send %02h mode %0d queued (expect %s code %0d)", b, mode, is_err ? "error" : "done", code);
    endtask

    task automatic wait_evt();
        int g = 0;
        while (n_events == ev_base && g < LIM) begin
            @(negedge clk);
            g++;
        end
        if (n_events == ev_base) begin
            n_cmp++;
            n_bad++;
            $display("FAIL evt_timeout: no done/error after %0d cycles, required one", LIM);
        end
    endtask

    task automatic wait_dev();
        int g = 0;
        while (dev_busy && g < LIM) begin
            @(negedge clk);
            g++;
        end
        if (dev_busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dev_timeout: device still busy after %0d cycles, required idle", LIM);
        end
        repeat (10) @(negedge clk);
    endtask

    // Monitor: every done/error pulse consumes one expected event.
    always @(negedge clk) begin
        evt_t e;
        if (!reset && (done === 1'b1 || error === 1'b1)) begin
            check("done_error_exclusive", {31'd0, done & error}, 32'd0);
            if (exp_evts.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: done=%0b error=%0b code=%0d, required none", done, error, err_code);
            end else begin
                e = exp_evts.pop_front();
                check("evt_error", {31'd0, error}, {31'd0, e.is_err});
                check("evt_done", {31'd0, done}, {31'd0, ~e.is_err});
                check("err_code", {30'd0, err_code}, {30'd0, e.code});
                $display("event done=%0b error=%0b code=%0d", done, error, err_code);
            end
            n_events++;
        end
    end

    // Device model: detects request-to-send, clocks 10 bits sampled on rising
    // edges, then ACKs (or not) on the 11th clock.
    initial begin : device
        int         low;
        bit         req;
        logic [9:0] bits;
        logic       start_b;
        frame_t     f;
        forever begin
            low = 0;
            req = 1'b0;
            while (!req) begin
                @(negedge clk);
                if (bus_clk === 1'b0) low++;
                else if (bus_dat === 1'b0 && low >= INH) req = 1'b1;
                else low = 0;
            end
            dev_busy = 1'b1;
            start_b  = bus_dat;
            if (dev_mode != M_NOCLK) begin
                dev_falls = 0;
                bits = '0;
                for (int i = 0; i < 10; i++) begin
                    repeat (HP) @(negedge clk);
                    dev_clk = 1'b0;
                    dev_falls++;
                    repeat (HP) @(negedge clk);
                    dev_clk = 1'b1;
                    bits[i] = bus_dat;
                end
                if (dev_mode == M_NORMAL) begin
                    repeat (HP/2) @(negedge clk);
                    dev_dat = 1'b0;
                    repeat (HP/2) @(negedge clk);
                    dev_clk = 1'b0;
                    dev_falls++;
                    repeat (HP) @(negedge clk);
                    dev_clk = 1'b1;
                    repeat (HP/2) @(negedge clk);
                    dev_dat = 1'b1;
                end else begin
                    repeat (HP) @(negedge clk);
                    dev_clk = 1'b0;
                    dev_falls++;
                    repeat (HP) @(negedge clk);
                    dev_clk = 1'b1;
                end
                if (dev_mode != M_ABORT) begin
                    if (exp_frames.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_frame: got data %02h, required none", bits[7:0]);
                    end else begin
                        f = exp_frames.pop_front();
                        check("start_bit", {31'd0, start_b}, 32'd0);
                        check("data_byte", {24'd0, bits[7:0]}, {24'd0, f.data});
                        check("parity_bit", {31'd0, bits[8]}, {31'd0, f.par});
                        check("stop_bit", {31'd0, bits[9]}, 32'd1);
                        $display("frame start=%0b data=%02h parity=%0b stop=%0b", start_b, bits[7:0], bits[8], bits[9]);
                    end
                end
            end
            dev_busy = 1'b0;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int         cnt;
        int         g;
        int         t0;
        int         t1;
        int         acc0;
        logic [7:0] b;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_send_ready", {31'd0, send_ready}, 32'd1);
        check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
        check("rst_rx_inhibit", {31'd0, rx_inhibit}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_err_code", {30'd0, err_code}, 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // 1: set-LEDs, parity 1, ACKed
        send(CMD_SET_LEDS, 1'b1, M_NORMAL, 1'b0, hcode);
        wait_evt();
        wait_dev();

        // 2: enable, parity 0; inhibit length and clock release ordering
        send(CMD_ENABLE, 1'b0, M_NORMAL, 1'b0, hcode);
        cnt = 0;
        g = 0;
        while (ps2_dat_oe !== 1'b1 && g < 4*INH) begin
            if (ps2_clk_oe === 1'b1) cnt++;
            g++;
            @(negedge clk);
        end
        check("inhibit_len_ge", {31'd0, cnt >= INH}, 32'd1);
        check("clk_oe_at_start", {31'd0, ps2_clk_oe}, 32'd1);
        check("rx_inhibit_busy", {31'd0, rx_inhibit}, 32'd1);
        @(negedge clk);
        check("clk_oe_released", {31'd0, ps2_clk_oe}, 32'd0);
        check("dat_oe_start", {31'd0, ps2_dat_oe}, 32'd1);
        wait_evt();
        wait_dev();

        // 3: device never clocks -> start timeout
        hcode = ERR_START;
        send(CMD_ENABLE, 1'b0, M_NOCLK, 1'b1, hcode);
        g = 0;
        while (ps2_dat_oe !== 1'b1 && g < 4*INH) begin
            g++;
            @(negedge clk);
        end
        t0 = cyc;
        g = 0;
        while (error !== 1'b1 && g < 2*START) begin
            g++;
            @(negedge clk);
        end
        t1 = cyc;
        check("start_timeout_cycles", t1 - t0, START);
        check("fail_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("fail_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
        @(negedge clk);
        check("fail_send_ready", {31'd0, send_ready}, 32'd1);
        wait_evt();
        wait_dev();

        // 4: device leaves data high at ACK
        hcode = ERR_NOACK;
        send(CMD_RESEND, 1'b0, M_NOACK, 1'b1, hcode);
        wait_evt();
        wait_dev();

        // 5: reset in the middle of the frame, then a clean send
        b = CMD_SET_LEDS;
        send(b, 1'b1, M_ABORT, 1'b0, hcode);
        g = 0;
        while (dev_falls < 5 && g < LIM) begin
            g++;
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check("dat_oe_k5", {31'd0, ps2_dat_oe}, {31'd0, ~b[4]});
        #2;
        reset = 1'b1;
        #1;
        check("arst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("arst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
        check("arst_send_ready", {31'd0, send_ready}, 32'd1);
        check("arst_err_code", {30'd0, err_code}, 32'd0);
        hcode = ERR_NONE;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_dev();
        send(CMD_RESET, 1'b1, M_NORMAL, 1'b0, hcode);
        wait_evt();
        wait_dev();

        // 6: send_valid held with changing data; one accept per transfer
        dev_mode = M_NORMAL;
        push_exp(CMD_ENABLE, 1'b0, M_NORMAL, 1'b0, hcode);
        ev_base = n_events;
        acc0 = n_acc;
        send_data = CMD_ENABLE;
        send_valid = 1'b1;
        g = 0;
        while (n_events == ev_base && g < LIM) begin
            @(negedge clk);
            #2;
            if (n_events == ev_base) send_data = send_data ^ 8'h3C;
            g++;
        end
        check("t6_first_done_seen", {31'd0, n_events != ev_base}, 32'd1);
        check("t6_single_accept", n_acc - acc0, 1);
        push_exp(CMD_RESEND, 1'b0, M_NORMAL, 1'b0, hcode);
        send_data = CMD_RESEND;
        ev_base = n_events;
        @(negedge clk);
        send_valid = 1'b0;
        check("t6_second_accept", n_acc - acc0, 2);
        check("t6_busy_after_accept", {31'd0, send_ready}, 32'd0);
        $display("send %02h then %02h with send_valid held", CMD_ENABLE, CMD_RESEND);
        wait_evt();
        wait_dev();

        check("queues_drained", exp_frames.size() + exp_evts.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
